// File: rtl/dlatch_stim_checker.sv
// Self-test driver/checker for a D-latch: drives D/rst, samples Q against a golden model.
// Optional: define DLATCH_STIM_INJECT_RST_EN to assert dut_rst on every vector with index mod 4 == 3.
module dlatch_stim_checker #(
    parameter int          NUM_VECTORS   = 16,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_q,
    output logic             dut_d,
    output logic             dut_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RST_PH = 3'd1;
    localparam logic [2:0] DRIVE  = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] SAMPLE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam int WAIT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(SETTLE_CYCLES);
    localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  VEC_LAST    = CNT_W'(NUM_VECTORS);

    logic [2:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        lfsr;
    logic              launch;
    logic              expected_q;
    logic [CNT_W-1:0]  vec_next;
    logic              inject_vec;

    // Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A new run may begin from IDLE, or from DONE once busy has dropped.
    assign launch     = start && !busy && ((state == IDLE) || (state == DONE));
    assign expected_q = dut_rst ? 1'b0 : dut_d;
    assign vec_next   = vec_count + CNT_W'(1);

`ifdef DLATCH_STIM_INJECT_RST_EN
    assign inject_vec = ((32'(vec_count) & 32'd3) == 32'd3);
`else
    assign inject_vec = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lfsr      <= LFSR_SEED;
            dut_d     <= 1'b0;
            dut_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
        end else if (launch) begin
            state     <= RST_PH;
            wait_cnt  <= '0;
            lfsr      <= LFSR_SEED;
            dut_d     <= 1'b0;
            dut_rst   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
        end else begin
            case (state)
                RST_PH: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (dut_q != 1'b0)
                            err_count <= sat_inc(err_count);
                        wait_cnt <= '0;
                        state    <= DRIVE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DRIVE: begin
                    dut_rst  <= inject_vec;
                    dut_d    <= inject_vec ? 1'b1 : lfsr[0];
                    lfsr     <= lfsr_step(lfsr);
                    wait_cnt <= '0;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    if (wait_cnt == SETTLE_LAST)
                        state <= SAMPLE;
                    else
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                SAMPLE: begin
                    if (dut_q != expected_q)
                        err_count <= sat_inc(err_count);
                    vec_count <= vec_next;
                    if (vec_next == VEC_LAST) begin
                        dut_rst <= 1'b1;
                        dut_d   <= 1'b0;
                        state   <= DONE;
                    end else begin
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for start.
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dlatch_stim_checker.sv
// Scoreboard bench for dlatch_stim_checker: behavioural latch models, directed runs.
module tb_dlatch_stim_checker;

    localparam int LAT  = 68;
    localparam int LAT2 = 16;
    localparam logic [15:0] D_TAB = 16'h6EE5;

`ifdef DLATCH_STIM_INJECT_RST_EN
    localparam int ERR_S0 = 8;
    localparam int ERR_S1 = 9;
    localparam int ERR_IR = 5;
`else
    localparam int ERR_S0 = 10;
    localparam int ERR_S1 = 7;
    localparam int ERR_IR = 0;
`endif

    logic clk = 1'b0;
    logic rst, start, start2;
    int   mode, mode2;

    logic       dut_q, dut_d, dut_rst, busy, done, pass;
    logic [7:0] err_count, vec_count;
    logic       s_q, s_d, s_rst, s_busy, s_done, s_pass;
    logic [1:0] s_err, s_vec;

    always #5 clk = ~clk;

    // 0 ideal, 1 stuck-0, 2 stuck-1, 3 ignores rst, 4 inverted
    function automatic logic model_q(input int m, input logic d, input logic r);
        case (m)
            0: return r ? 1'b0 : d;
            1: return 1'b0;
            2: return 1'b1;
            3: return d;
            default: return ~(r ? 1'b0 : d);
        endcase
    endfunction

    assign dut_q = model_q(mode, dut_d, dut_rst);
    assign s_q   = model_q(mode2, s_d, s_rst);

    dlatch_stim_checker dut (
        .clk(clk), .rst(rst), .start(start), .dut_q(dut_q), .dut_d(dut_d),
        .dut_rst(dut_rst), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_count(vec_count)
    );

    dlatch_stim_checker #(.NUM_VECTORS(3), .SETTLE_CYCLES(2), .LFSR_SEED(8'h09), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .dut_q(s_q), .dut_d(s_d),
        .dut_rst(s_rst), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .vec_count(s_vec)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int    vec;
        int    err;
        int    pss;
        int    done_cyc;
        string tag;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];
    exp_t m1, m2;
    logic done_d  = 1'b0;
    logic sdone_d = 1'b0;

    always @(negedge clk) begin
        if (done && !done_d) begin
            if (sb1.size() == 0) begin
                check("main_unexpected_done", 1, 0);
            end else begin
                m1 = sb1.pop_front();
                check({m1.tag, "_vec"}, 32'(vec_count), m1.vec);
                check({m1.tag, "_err"}, 32'(err_count), m1.err);
                check({m1.tag, "_pass"}, 32'(pass), m1.pss);
                check({m1.tag, "_done_cycle"}, cyc, m1.done_cyc);
            end
        end
        done_d = done;
    end

    always @(negedge clk) begin
        if (s_done && !sdone_d) begin
            if (sb2.size() == 0) begin
                check("small_unexpected_done", 1, 0);
            end else begin
                m2 = sb2.pop_front();
                check({m2.tag, "_vec"}, 32'(s_vec), m2.vec);
                check({m2.tag, "_err"}, 32'(s_err), m2.err);
                check({m2.tag, "_pass"}, 32'(s_pass), m2.pss);
                check({m2.tag, "_done_cycle"}, cyc, m2.done_cyc);
            end
        end
        sdone_d = s_done;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dut_d"}, 32'(dut_d), 0);
        check({tag, "_dut_rst"}, 32'(dut_rst), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_err"}, 32'(err_count), 0);
        check({tag, "_vec"}, 32'(vec_count), 0);
    endtask

    task automatic run(input string tag, input bit chk_seq, input int repulse_at,
                       input int abort_at, input int ev, input int ee, input int ep);
        int   s, k;
        bit   busy_ok, seen;
        logic er, ed;
        exp_t e;
        @(negedge clk);
        s = cyc + 1;
        if (abort_at == 0) begin
            e.vec = ev; e.err = ee; e.pss = ep; e.done_cyc = s + LAT; e.tag = tag;
            sb1.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_ok = 1'b1;
        seen = 1'b0;
        k = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
            if (abort_at > 0 && cyc - s == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs({tag, "_in_rst"});
                @(negedge clk);
                @(negedge clk);
                check({tag, "_in_rst_done"}, 32'(done), 0);
                rst = 1'b0;
                return;
            end
            if (chk_seq && k < 16 && cyc - s == 5 + 4 * k) begin
                er = 1'b0;
                ed = D_TAB[k];
`ifdef DLATCH_STIM_INJECT_RST_EN
                if (k % 4 == 3) begin
                    er = 1'b1;
                    ed = 1'b1;
                end
`endif
                check($sformatf("%s_vec%0d_rst_d", tag, k), 32'({dut_rst, dut_d}), 32'({er, ed}));
                k++;
            end
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
            if (!seen) begin
                start = (repulse_at > 0 && cyc - s + 1 == repulse_at);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            check({tag, "_busy_during_run"}, 32'(busy_ok), 1);
            check({tag, "_busy_after"}, 32'(busy), 0);
            check({tag, "_idle_drive"}, 32'({dut_rst, dut_d}), 32'(2'b10));
            if (chk_seq) check({tag, "_vectors_logged"}, k, 16);
        end
    endtask

    task automatic run2(input string tag, input int ev, input int ee, input int ep);
        int   s;
        bit   seen;
        exp_t e;
        @(negedge clk);
        s = cyc + 1;
        e.vec = ev; e.err = ee; e.pss = ep; e.done_cyc = s + LAT2; e.tag = tag;
        sb2.push_back(e);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            if (s_done) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        mode = 0;
        mode2 = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");
        check("small_idle_done", 32'(s_done), 0);

        run("ideal", 1, 0, 0, 16, 0, 1);
        mode = 1;
        run("stuck0", 1, 0, 0, 16, ERR_S0, 0);
        mode = 2;
        run("stuck1", 1, 0, 0, 16, ERR_S1, 0);
        mode = 0;
        run("repulse", 0, 20, 0, 16, 0, 1);
        run("abort", 0, 0, 30, 0, 0, 0);
        run("fresh", 1, 0, 0, 16, 0, 1);
        mode = 3;
        run("ignore_rst", 1, 0, 0, 16, ERR_IR, (ERR_IR == 0) ? 1 : 0);
        mode = 0;

        mode2 = 1;
        run2("sat_stuck0", 3, 3, 0);
        mode2 = 4;
        run2("sat_inverted", 3, 3, 0);
        mode2 = 0;
        run2("small_ideal", 3, 0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb1.size() + sb2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dlatch_stim_checker.md
Name: dlatch_stim_checker

Overview:
- Synthesizable driver/checker sitting on the far side of the D-latch interface.
- Drives the latch's D and rst inputs and observes its Q output.
- Feeds a pseudo-random data sequence, compares Q against an internal golden latch model, and reports error/vector counts plus a pass flag.
- Used for on-board self-test of latch instances and as a reusable bench component.

Parameters:
- NUM_VECTORS, 16, number of data vectors applied per run (1..2^CNT_W-1).
- SETTLE_CYCLES, 2, clock cycles waited after changing dut outputs before sampling dut_q (>=1).
- LFSR_SEED, 8'hA5, non-zero initial LFSR state loaded on each start.
- CNT_W, 8, width of err_count and vec_count.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to begin a run; ignored while busy.
- dut_q  input  1  Q output of the latch under test (synchronous to clk by construction).
- dut_d  output  1  D drive to latch under test.
- dut_rst  output  1  reset drive to latch under test (active-high).
- busy  output  1  high from the cycle after start is accepted until done rises.
- done  output  1  high after run completion; held until next accepted start.
- pass  output  1  valid when done=1: 1 iff err_count==0.
- err_count  output  CNT_W  number of mismatches this run, saturating at all-ones.
- vec_count  output  CNT_W  number of data vectors sampled this run.

Behaviour:
- Reset values: dut_d=0, dut_rst=1 (DUT held cleared), busy=0, done=0, pass=0, err_count=0, vec_count=0, lfsr=LFSR_SEED, FSM=IDLE.
- Golden model: expected Q = dut_rst ? 0 : dut_d, using the values driven during the settle window.
- FSM states: IDLE, RST_PH, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: when start=1, clear counters, load lfsr=LFSR_SEED, done=0, busy=1 -> RST_PH.
- RST_PH: dut_rst=1, dut_d=0 for SETTLE_CYCLES cycles, then one sample cycle comparing dut_q to 0. A mismatch increments err_count. vec_count is not incremented. -> DRIVE.
- DRIVE (1 cycle): dut_rst=0, dut_d=lfsr[0], advance lfsr one step (Fibonacci, taps 8,6,5,4; new bit = l[7]^l[5]^l[4]^l[3] shifted into l[0]) -> SETTLE.
- SETTLE: hold dut outputs for SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE (1 cycle): compare dut_q with expected; mismatch increments err_count (saturating); vec_count++. If the new vec_count==NUM_VECTORS -> DONE, else -> DRIVE.
- DONE: busy=0, done=1, pass=(err_count==0), dut_rst=1, dut_d=0. Next start re-runs from IDLE actions (start accepted directly in DONE).
- Latency: done rises 1+(SETTLE_CYCLES+1)+NUM_VECTORS*(SETTLE_CYCLES+2) cycles after the edge that samples start (68 with defaults).
- start during busy: ignored, no restart.
- rst mid-run: asynchronously returns all outputs to reset values; counts are lost; done stays 0.
- err_count saturation: stays at 2^CNT_W-1; pass=0.

Optional Feature:
- Macro DLATCH_STIM_INJECT_RST_EN.
- Defined: every vector whose index mod 4 == 3 (0-based) drives dut_rst=1, dut_d=1 in DRIVE, expected Q=0. The LFSR still advances on those vectors. Such vectors count in vec_count.
- Undefined: dut_rst is asserted only in RST_PH and DONE.

Test Plan:
- Ideal latch model, defaults, single start pulse -> done rises exactly 68 cycles later; vec_count=16, err_count=0, pass=1; busy high for the interval.
- Q stuck-at-0 DUT -> err_count = number of dut_d=1 vectors logged by bench; pass=0. Q stuck-at-1 DUT -> err_count = 1 + number of dut_d=0 vectors. Sum of the two runs = 17.
- start re-pulsed at cycle 20 of a run -> ignored; done still at cycle 68; vec_count=16.
- rst asserted at cycle 30 for 2 cycles, then start -> outputs at reset values during rst (dut_rst=1, counts 0); fresh run completes with identical dut_d sequence starting from seed A5.
- CNT_W=2, stuck-at-0 DUT with >=3 ones -> err_count saturates at 3, pass=0.
- DLATCH_STIM_INJECT_RST_EN defined, ideal DUT -> dut_rst=1 on vectors 3, 7, 11, 15; err_count=0, pass=1. DUT ignoring rst -> err_count=4 (vectors 3, 7, 11, 15 each expect 0 with dut_d=1) + 1 for the RST_PH check = 5.
